credit_based_transmitter: RTL
=============================

# credit_based_transmitter

Upstream companion to the credit-based FIFO: accepts words from a valid/ready producer and forwards them over a credit-based link, sending only while it holds credits. It starts with a full credit budget equal to the receiver's buffer depth. It spends one credit per word sent and regains one credit per returned credit pulse. It sits directly in front of the receiving credit-based FIFO and drives its `write_data`/`write_valid`, consuming its `write_credit`.

## Interface
- `WIDTH`, 8, data word width in bits.
- `CREDIT_COUNT`, 4, initial and maximum credits; must equal receiver buffer depth; ≥1.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `input_data`  in  WIDTH  producer data.
- `input_valid`  in  1  producer has a word.
- `input_ready`  out  1  transmitter can accept a word this cycle.
- `output_data`  out  WIDTH  link data, registered.
- `output_valid`  out  1  one-cycle pulse per word on the link, registered.
- `output_credit`  in  1  one-cycle pulse returning one credit from the receiver.
- `credit_count`  out  CLOG2(CREDIT_COUNT+1)  credits currently held.
- `idle`  out  1  all credits home (`credit_count == CREDIT_COUNT`) and `output_valid` low.
- `credit_overflow`  out  1  sticky error flag; a credit was returned while the counter was already at `CREDIT_COUNT`.

## Operation
- Counter width is CLOG2(CREDIT_COUNT+1) so that it can hold the value `CREDIT_COUNT`.
- `input_ready = (credit_count != 0)`. This is combinational from the register only. A credit arriving this cycle does not raise `input_ready` this cycle; there is no bypass.
- A transfer occurs when `input_valid && input_ready`.
- On a transfer:
  - `output_data <= input_data`.
  - `output_valid <= 1`.
- Otherwise `output_valid <= 0` and `output_data` holds its value.
- Counter update: next = count − transfer + `output_credit`.
  - A transfer and a credit in the same cycle leave the count unchanged.
  - The counter never underflows, because a transfer requires count ≥ 1.
- Overflow case: `output_credit` while count == `CREDIT_COUNT` and no transfer.
  - The count saturates at `CREDIT_COUNT`.
  - `credit_overflow <= 1` and stays high until reset.
- A credit in the same cycle as a transfer at count == `CREDIT_COUNT` is legal and is not an overflow.
- `input_valid` while `input_ready` is low has no effect. The producer must hold its data until it sees ready; this is standard valid/ready.
- No state machine beyond the counter: the states are the counter values 0..`CREDIT_COUNT`.

## Timing
- Reset values (synchronous):
  - `credit_count = CREDIT_COUNT`
  - `output_valid = 0`
  - `output_data = 0`
  - `credit_overflow = 0`
  - `idle = 1`
  - `input_ready = 1`
- Reset takes priority over every other input in the same cycle.
- Reset mid-operation: in-flight words are dropped, the credit budget returns to full, and the sticky flag is cleared. The receiver must be reset in the same cycle.
- Latency is 1 cycle: the word accepted in cycle N appears with `output_valid` in cycle N+1.
- Throughput is 1 word/cycle while credits remain.
- Credit turnaround: a credit pulse in cycle N updates the count at N+1. If the count was 0, `input_ready` rises at N+1.
- Back-to-back sends from full: `CREDIT_COUNT` consecutive words are accepted, then `input_ready` drops in the following cycle.

## Structure
- No shared package is required. `CLOG2` comes from the common header.
- One natural sub-module, `credit_counter`:
  - Parameterised up/down saturating counter, loaded with `CREDIT_COUNT` at reset.
  - Inputs: `decrement`, `increment`.
  - Outputs: `count`, `nonzero`, `at_max`, `overflow`.
- The top level holds the output data/valid register and the handshake.

## Test plan
- Reset, then idle: `credit_count` = 4, `input_ready` = 1, `idle` = 1, `output_valid` = 0, `credit_overflow` = 0.
- Burst with `input_valid` held high for 6 cycles, data 0x10..0x15, no credits returned:
  - 0x10..0x13 appear on `output_data` in cycles 1–4 with `output_valid` high.
  - `input_ready` is 0 from cycle 4.
  - 0x14 is held by the producer; count = 0.
- Starved recovery: with count 0, pulse `output_credit` in cycle N.
  - `input_ready` is 0 in cycle N and 1 in N+1.
  - 0x14 transfers at N+1 and is output at N+2; count returns to 0.
- Simultaneous events: at count 2, assert a transfer and `output_credit` in the same cycle.
  - Count stays 2.
  - One word is output next cycle.
  - No overflow.
- Overflow: at count 4 with no transfer, pulse `output_credit`.
  - Count stays 4.
  - `credit_overflow` goes to 1 and stays high through further traffic until `reset`, after which it is 0.
- Reset mid-burst: assert `reset` with count 1 and `output_valid` high.
  - The next cycle shows count 4, `output_valid` 0, `output_data` 0.

Source files
------------

// File: rtl/credit_based_transmitter_pkg.sv
// Shared types for the credit-based transmitter: the credit counter's
// per-cycle operation and the helper that selects it.
package credit_based_transmitter_pkg;

    typedef enum logic [1:0] {
        CREDIT_HOLD     = 2'd0,
        CREDIT_SPEND    = 2'd1,
        CREDIT_GAIN     = 2'd2,
        CREDIT_SATURATE = 2'd3
    } credit_op_e;

    // A spend and a return in the same cycle cancel, even at the maximum.
    function automatic credit_op_e credit_op(input logic decrement,
                                             input logic increment,
                                             input logic at_max);
        credit_op_e op;
        op = CREDIT_HOLD;
        if (decrement && !increment) begin
            op = CREDIT_SPEND;
        end else if (increment && !decrement) begin
            op = at_max ? CREDIT_SATURATE : CREDIT_GAIN;
        end
        return op;
    endfunction

endpackage

// File: rtl/credit_based_transmitter_credit_counter.sv
// Up/down saturating credit counter, loaded with the full budget at reset,
// with a sticky flag for credits returned while already full.
module credit_counter
    import credit_based_transmitter_pkg::*;
#(
    parameter int CREDIT_COUNT = 4,
    parameter int CNT_W        = $clog2(CREDIT_COUNT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             decrement,
    input  logic             increment,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(CREDIT_COUNT);

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    credit_op_e       op;

    assign nonzero  = (count_q != '0);
    assign at_max   = (count_q == MAX_COUNT);
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        op         = credit_op(decrement, increment, at_max);
        case (op)
            CREDIT_SPEND:    count_d = count_q - CNT_W'(1);
            CREDIT_GAIN:     count_d = count_q + CNT_W'(1);
            CREDIT_SATURATE: overflow_d = 1'b1;
            default:         ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= MAX_COUNT;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/credit_based_transmitter.sv
// Valid/ready to credit-based link bridge: forwards one registered word per
// accepted transfer while credits remain.
module credit_based_transmitter
    import credit_based_transmitter_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CREDIT_COUNT = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [WIDTH-1:0]                   input_data,
    input  logic                               input_valid,
    output logic                               input_ready,
    output logic [WIDTH-1:0]                   output_data,
    output logic                               output_valid,
    input  logic                               output_credit,
    output logic [$clog2(CREDIT_COUNT+1)-1:0]  credit_count,
    output logic                               idle,
    output logic                               credit_overflow
);

    localparam int CNT_W = $clog2(CREDIT_COUNT + 1);

    logic [WIDTH-1:0] output_data_q, output_data_d;
    logic             output_valid_q, output_valid_d;
    logic             transfer;
    logic             credit_nonzero;
    logic             credit_at_max;

    // Ready depends only on the registered count; a returning credit is
    // not bypassed into the same cycle.
    assign input_ready = credit_nonzero;
    assign transfer    = input_valid && credit_nonzero;

    credit_counter #(
        .CREDIT_COUNT (CREDIT_COUNT),
        .CNT_W        (CNT_W)
    ) u_credit_counter (
        .clock     (clock),
        .reset     (reset),
        .decrement (transfer),
        .increment (output_credit),
        .count     (credit_count),
        .nonzero   (credit_nonzero),
        .at_max    (credit_at_max),
        .overflow  (credit_overflow)
    );

    always_comb begin
        output_data_d  = output_data_q;
        output_valid_d = transfer;
        if (transfer) begin
            output_data_d = input_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            output_data_q  <= '0;
            output_valid_q <= 1'b0;
        end else begin
            output_data_q  <= output_data_d;
            output_valid_q <= output_valid_d;
        end
    end

    assign output_data  = output_data_q;
    assign output_valid = output_valid_q;
    assign idle         = credit_at_max && !output_valid_q;

endmodule
